// File: rtl/dpr_tx_reader.sv
// Port-B read sequencer: drains a block of up to 32 words from the message buffer onto a valid/ready stream.
// Optional odd-parity output is enabled by defining DPR_TX_PARITY_EN; otherwise TX_PAR is tied low.
`timescale 1ns/1ps
module dpr_tx_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [4:0]        WORD_COUNT,
  input  logic              ABORT,
  output logic [ADDR_W-1:0] B_ADDR,
  output logic              B_WEN,
  output logic [DATA_W-1:0] B_DIN,
  input  logic [DATA_W-1:0] B_DOUT,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_PAR,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    FETCH   = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [5:0]        count_reg, count_next;
  logic [DATA_W-1:0] tx_data_reg, tx_data_next;
  logic              tx_valid_reg, tx_valid_next;
  logic              done_reg, done_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_reg     <= '0;
      count_reg    <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      addr_reg     <= addr_next;
      count_reg    <= count_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    count_next    = count_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        // ABORT takes priority over a simultaneous START
        if (START && !ABORT) begin
          addr_next  = START_ADDR;
          count_next = (WORD_COUNT == 5'd0) ? 6'd32 : {1'b0, WORD_COUNT};
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = FETCH;
      end
      FETCH: begin
        tx_data_next  = B_DOUT;
        tx_valid_next = 1'b1;
        state_next    = PRESENT;
      end
      PRESENT: begin
        if (TX_READY) begin
          tx_valid_next = 1'b0;
          addr_next     = addr_reg + ADDR_W'(1);
          count_next    = count_reg - 6'd1;
          if (count_reg == 6'd1) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort cancels everything, including a handshake in the same cycle
    if (ABORT && (state_reg != IDLE)) begin
      state_next    = IDLE;
      addr_next     = addr_reg;
      count_next    = count_reg;
      tx_data_next  = tx_data_reg;
      tx_valid_next = 1'b0;
      done_next     = 1'b0;
    end
  end

`ifdef DPR_TX_PARITY_EN
  logic tx_par_reg;

  // Parity is captured with the data word so both change on the same edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_par_reg <= 1'b0;
    end else if ((state_reg == FETCH) && !ABORT) begin
      tx_par_reg <= ~^B_DOUT;
    end
  end

  assign TX_PAR = tx_par_reg;
`else
  assign TX_PAR = 1'b0;
`endif

  assign B_ADDR   = addr_reg;
  assign B_WEN    = 1'b0;
  assign B_DIN    = '0;
  assign TX_DATA  = tx_data_reg;
  assign TX_VALID = tx_valid_reg;
  assign BUSY     = (state_reg != IDLE);
  assign DONE     = done_reg;

endmodule

// File: tb/tb_dpr_tx_reader.sv
// Directed self-checking bench for dpr_tx_reader with a registered-read buffer model on port B.
`timescale 1ns/1ps
module tb_dpr_tx_reader;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [4:0]        word_count;
  logic              abort;
  logic [ADDR_W-1:0] b_addr;
  logic              b_wen;
  logic [DATA_W-1:0] b_din;
  logic [DATA_W-1:0] b_dout;
  logic [DATA_W-1:0] tx_data;
  logic              tx_par;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [32];

  int checks   = 0;
  int failures = 0;

  dpr_tx_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(clk), .RST(rst), .START(start), .START_ADDR(start_addr),
    .WORD_COUNT(word_count), .ABORT(abort), .B_ADDR(b_addr), .B_WEN(b_wen),
    .B_DIN(b_din), .B_DOUT(b_dout), .TX_DATA(tx_data), .TX_PAR(tx_par),
    .TX_VALID(tx_valid), .TX_READY(tx_ready), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // Buffer port B: read data valid one cycle after the address
  always @(posedge clk) b_dout <= mem[b_addr];

  function automatic logic exp_par(input logic [DATA_W-1:0] d);
`ifdef DPR_TX_PARITY_EN
    return ~^d;
`else
    return (^d) & 1'b0;
`endif
  endfunction

  task automatic start_block(input logic [ADDR_W-1:0] a, input logic [4:0] wc);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; word_count = wc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; start_addr = 5'd9; word_count = 5'd1; abort = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, tx_valid, done, tx_par, b_wen} !== 5'b0 || b_addr !== 5'd0 || tx_data !== 16'd0 || b_din !== 16'd0) begin
      failures++;
      $display("FAIL reset_vals: busy=%b valid=%b done=%b par=%b wen=%b addr=%0d data=%h din=%h required all 0",
               busy, tx_valid, done, tx_par, b_wen, b_addr, tx_data, b_din);
    end
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_ignored: busy=%b required 0", busy); end
    $display("reset: idle after release busy=%b", busy);

    // asynchronous reset in the middle of a transfer
    tx_ready = 1'b0;
    start_block(5'd12, 5'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== mem[12]) begin
      failures++; $display("FAIL midreset_pre: valid=%b data=%h required 1 %h", tx_valid, tx_data, mem[12]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, tx_valid, done, tx_par} !== 4'b0 || b_addr !== 5'd0 || tx_data !== 16'd0) begin
      failures++;
      $display("FAIL midreset_async: busy=%b valid=%b done=%b par=%b addr=%0d data=%h required all 0",
               busy, tx_valid, done, tx_par, b_addr, tx_data);
    end
    @(posedge clk); #1;
    rst = 1'b0; tx_ready = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin failures++; $display("FAIL midreset_no_done: active cycles=%0d required 0", seen); end
    end
    $display("reset: mid-transfer reset cleared outputs");
  endtask

  task automatic test_single_word;
    tx_ready = 1'b1;
    start_block(5'd5, 5'd1);
    checks++;
    if (busy !== 1'b1 || b_addr !== 5'd5 || tx_valid !== 1'b0) begin
      failures++; $display("FAIL single_e0: busy=%b addr=%0d valid=%b required 1 5 0", busy, b_addr, tx_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL single_e1: valid=%b busy=%b required 0 1", tx_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 16'hA5C3 || tx_par !== exp_par(16'hA5C3)) begin
      failures++; $display("FAIL single_e2: valid=%b data=%h par=%b required 1 a5c3 %b",
                           tx_valid, tx_data, tx_par, exp_par(16'hA5C3));
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++; $display("FAIL single_e3: done=%b busy=%b valid=%b required 1 0 0", done, busy, tx_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse: done=%b required 0", done); end
    $display("single: word=%h par=%b", tx_data, tx_par);
  endtask

  task automatic test_wrap_full;
    int hs = 0;
    int done_cyc = -1;
    tx_ready = 1'b1;
    start_block(5'd30, 5'd0);
    for (int c = 1; c <= 200; c++) begin
      logic [DATA_W-1:0] e;
      @(posedge clk); #1;
      if (tx_valid) begin
        e = mem[(30 + hs) % 32];
        checks++;
        if (hs >= 32 || tx_data !== e || tx_par !== exp_par(e)) begin
          failures++; $display("FAIL wrap_word%0d: data=%h par=%b required %h %b", hs, tx_data, tx_par, e, exp_par(e));
        end
        hs++;
      end
      if (done) begin done_cyc = c; break; end
    end
    checks++;
    if (done_cyc !== 96 || hs !== 32) begin
      failures++; $display("FAIL wrap_total: done_cycle=%0d words=%0d required 96 32", done_cyc, hs);
    end
    $display("wrap: %0d words, done at cycle %0d", hs, done_cyc);
  endtask

  task automatic test_backpressure;
    int hs = 0;
    int cyc = 0;
    int done_cyc = -1;
    bit stalled = 0;
    tx_ready = 1'b1;
    start_block(5'd10, 5'd3);
    while (cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (done) begin done_cyc = cyc; break; end
      if (tx_valid) begin
        if (hs == 1 && !stalled) begin
          int bad = 0;
          tx_ready = 1'b0;
          for (int s = 0; s < 10; s++) begin
            @(posedge clk); #1; cyc++;
            if (tx_valid !== 1'b1 || tx_data !== mem[11]) bad++;
          end
          checks++;
          if (bad !== 0) begin
            failures++; $display("FAIL bp_hold: unstable cycles=%0d data=%h required 0 %h", bad, tx_data, mem[11]);
          end
          tx_ready = 1'b1; stalled = 1;
        end
        checks++;
        if (hs >= 3 || tx_data !== mem[10 + hs]) begin
          failures++; $display("FAIL bp_word%0d: data=%h required %h", hs, tx_data, mem[(10 + hs) % 32]);
        end
        hs++;
      end
    end
    checks++;
    if (hs !== 3 || done_cyc !== 19) begin
      failures++; $display("FAIL bp_total: words=%0d done_cycle=%0d required 3 19", hs, done_cyc);
    end
    $display("backpressure: %0d words, done at cycle %0d", hs, done_cyc);
  endtask

  task automatic test_abort;
    int hs = 0;
    int cyc = 0;
    int early_done = 0;
    bit aborted = 0;
    tx_ready = 1'b1;
    start_block(5'd0, 5'd8);
    while (cyc < 60 && !aborted) begin
      @(posedge clk); #1; cyc++;
      if (done) early_done++;
      if (tx_valid) begin
        if (hs == 3) begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0; aborted = 1;
          checks++;
          if (busy !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_state: busy=%b valid=%b done=%b required 0 0 0", busy, tx_valid, done);
          end
        end else begin
          hs++;
        end
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) early_done++;
    end
    checks++;
    if (!aborted || early_done !== 0) begin
      failures++; $display("FAIL abort_no_done: aborted=%b stray cycles=%0d required 1 0", aborted, early_done);
    end
    // a fresh transfer after the abort
    hs = 0;
    start_block(5'd7, 5'd2);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (tx_valid) begin
        checks++;
        if (hs >= 2 || tx_data !== mem[7 + hs]) begin
          failures++; $display("FAIL abort_restart_word%0d: data=%h required %h", hs, tx_data, mem[(7 + hs) % 32]);
        end
        hs++;
      end
      if (done) begin
        checks++;
        if (c !== 6 || hs !== 2) begin
          failures++; $display("FAIL abort_restart_done: cycle=%0d words=%0d required 6 2", c, hs);
        end
        break;
      end
      if (c == 30) begin
        checks++; failures++; $display("FAIL abort_restart_timeout: done=0 required 1");
      end
    end
    $display("abort: aborted at word 4, restart words=%0d", hs);
  endtask

  task automatic test_ignored_start;
    int hs = 0;
    int done_cyc = -1;
    int stray = 0;
    tx_ready = 1'b1;
    start_block(5'd20, 5'd2);
    start = 1'b1; start_addr = 5'd3; word_count = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (b_addr !== 5'd20 || busy !== 1'b1) begin
      failures++; $display("FAIL busy_start_addr: addr=%0d busy=%b required 20 1", b_addr, busy);
    end
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); #1;
      if (tx_valid) begin
        checks++;
        if (hs >= 2 || tx_data !== mem[20 + hs]) begin
          failures++; $display("FAIL busy_start_word%0d: data=%h required %h", hs, tx_data, mem[(20 + hs) % 32]);
        end
        hs++;
      end
      if (done) begin done_cyc = c; break; end
    end
    checks++;
    if (done_cyc !== 6 || hs !== 2) begin
      failures++; $display("FAIL busy_start_total: done_cycle=%0d words=%0d required 6 2", done_cyc, hs);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (busy) stray++;
    end
    // START together with ABORT in IDLE
    start = 1'b1; abort = 1'b1; start_addr = 5'd9; word_count = 5'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    if (busy) stray++;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (busy || tx_valid || done) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++; $display("FAIL ignored_start: active cycles=%0d required 0", stray);
    end
    $display("ignored_start: words=%0d done at %0d stray=%0d", hs, done_cyc, stray);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h3C00 + 16'(i * 16'h0111);
    mem[5] = 16'hA5C3;
    test_reset();
    test_single_word();
    test_wrap_full();
    test_backpressure();
    test_abort();
    test_ignored_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpr_tx_reader.md
# dpr_tx_reader

Port-B read sequencer for the 16x32 dual-port message buffer. On a start command it fetches a block of up to 32 words from the buffer starting at a given subaddress offset. It presents the words one at a time on a valid/ready stream to the MIL-STD-1553 transmit encoder. It is the consumer end of the buffer: the bus-side logic writes through port A, and this block drains through port B.

## Interface
Parameters:
- ADDR_W, 5, buffer address width (32 words)
- DATA_W, 16, word width (1553 data word)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  one-cycle request to begin a block read; sampled only in IDLE
- START_ADDR  in  ADDR_W  first buffer address of the block
- WORD_COUNT  in  5  1553 word count; 0 encodes 32 words
- ABORT  in  1  cancel the transfer in progress
- B_ADDR  out  ADDR_W  registered read address to buffer port B
- B_WEN  out  1  port-B write enable; constant 0
- B_DIN  out  DATA_W  port-B write data; constant 0
- B_DOUT  in  DATA_W  port-B read data, valid one cycle after B_ADDR
- TX_DATA  out  DATA_W  word presented to the encoder
- TX_PAR  out  1  odd parity of TX_DATA (see Configuration)
- TX_VALID  out  1  TX_DATA/TX_PAR valid
- TX_READY  in  1  encoder accepts the word
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, ISSUE, FETCH, PRESENT.
- **IDLE**: if START=1 and ABORT=0, latch START_ADDR into the address register. Latch the remaining count as WORD_COUNT, or 32 if WORD_COUNT=0, into a 6-bit counter. Go to ISSUE. Otherwise stay.
- **ISSUE**: B_ADDR holds the current address. Go to FETCH.
- **FETCH**: B_DOUT is valid. At the clock edge, capture it into TX_DATA and set TX_VALID=1. Go to PRESENT.
- **PRESENT**: hold TX_DATA/TX_VALID stable until TX_READY=1. On the handshake, clear TX_VALID, increment the address mod 32 (31 wraps to 0), and decrement the remaining count.
  - Remaining count now 0: go to IDLE and pulse DONE.
  - Otherwise: go to ISSUE.
- BUSY=1 in ISSUE, FETCH and PRESENT; BUSY=0 in IDLE.
- START outside IDLE is ignored.
- ABORT in any non-IDLE state: go to IDLE on the next edge, clear TX_VALID, and do not pulse DONE. ABORT overrides a same-cycle handshake.
- START and ABORT together in IDLE: ABORT wins and no transfer starts.
- Block data is never modified; B_WEN and B_DIN are tied to 0.

## Timing
- Reset values: B_ADDR=0, TX_DATA=0, TX_PAR=0, TX_VALID=0, BUSY=0, DONE=0, state=IDLE.
- START sampled at edge e0: B_ADDR=START_ADDR and BUSY=1 from e0.
- First TX_VALID rises at e0+2.
- Per-word minimum period is 3 cycles (ISSUE, FETCH, PRESENT with TX_READY already high).
- A 32-word block with TX_READY tied high takes 96 cycles from START to DONE.
- DONE is high for the single cycle after the final handshake edge. BUSY falls on the same edge.
- TX_DATA changes only at the FETCH edge and holds through backpressure of any length.
- RST mid-transfer: all outputs return to reset values asynchronously. No DONE.

## Configuration
- Macro DPR_TX_PARITY_EN.
- Defined: TX_PAR is registered alongside TX_DATA at the FETCH edge as odd parity, so XOR of TX_DATA and TX_PAR equals 1.
- Undefined: no parity logic; TX_PAR is constant 0.
- Port list is identical in both builds.

## Test plan
- Reset then idle: assert RST mid-cycle -> all outputs 0 immediately. START ignored while RST=1.
- Single word: buffer[5]=0xA5C3, START_ADDR=5, WORD_COUNT=1, TX_READY=1 -> TX_VALID at e0+2 with TX_DATA=0xA5C3 (TX_PAR=1 with macro). DONE at e0+3.
- Wrap and full block: START_ADDR=30, WORD_COUNT=0 -> 32 words read from addresses 30, 31, 0, …, 29 in order. DONE after exactly 96 cycles with TX_READY=1.
- Backpressure: WORD_COUNT=3, TX_READY low for 10 cycles on word 2 -> TX_DATA stable throughout. No skipped or duplicated words. Still exactly 3 handshakes.
- Abort: ABORT during PRESENT of word 4 of 8 -> IDLE next cycle, TX_VALID=0, BUSY=0, DONE never pulses. A subsequent START works normally.
- START while BUSY and START+ABORT in IDLE -> both ignored. Transfer count and addresses unchanged.
